// File: rtl/id_stage_if.sv
// Fetch <-> decode handshake bundle.
//   master (fetch) : drives if_valid_in / if_pc_in / if_instr_in,
//                    observes id_allowin_out and the branch-resolution return path.
//   slave (decode) : the reverse directions.
// Signal names match the original flat ports so existing fetch logic maps 1:1.
interface id_stage_if;
    logic        if_valid_in;
    logic [31:0] if_pc_in;
    logic [31:0] if_instr_in;
    logic        id_allowin_out;
    logic        id_brcal_res_out;
    logic [31:0] id_bjpc_res_out;

    modport master (
        output if_valid_in, if_pc_in, if_instr_in,
        input  id_allowin_out, id_brcal_res_out, id_bjpc_res_out
    );

    modport slave (
        input  if_valid_in, if_pc_in, if_instr_in,
        output id_allowin_out, id_brcal_res_out, id_bjpc_res_out
    );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline.
// Latches PC/instruction from fetch, reads the register file, forwards from
// EX/MEM, detects load-use hazards and resolves branches/jumps in-stage.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   fs                     : fetch handshake + branch return path (id_stage_if.slave)
//   rf_raddr1/2, rf_rdata1/2 : register-file read ports (rs, rt)
//   ex_*_in, mem_*_in      : forwarding / hazard sources from EX and MEM
//   ex_allowin_in          : EX back-pressure
//   id_*_out               : decoded instruction presented to EX
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    id_stage_if.slave   fs,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        ex_valid_in,
    input  logic        ex_wen_in,
    input  logic        ex_is_load_in,
    input  logic [4:0]  ex_waddr_in,
    input  logic [31:0] ex_wdata_in,
    input  logic        mem_valid_in,
    input  logic        mem_wen_in,
    input  logic [4:0]  mem_waddr_in,
    input  logic [31:0] mem_wdata_in,
    input  logic        ex_allowin_in,
    output logic        id_valid_out,
    output logic [31:0] id_pc_out,
    output logic [31:0] id_instr_out,
    output logic [31:0] id_rs_val_out,
    output logic [31:0] id_rt_val_out,
    output logic [31:0] id_imm_ext_out,
    output logic [4:0]  id_dest_out
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    logic        valid_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;

    logic        stall;
    logic        ready;
    logic        uses_rs;
    logic        uses_rt;
    logic        is_br;
    logic        is_jmp;
    logic        cond;
    logic [4:0]  dest;
    logic [31:0] imm_ext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        ex_fwd_ok;
    logic        mem_fwd_ok;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign op    = instr_r[31:26];
    assign rs    = instr_r[25:21];
    assign rt    = instr_r[20:16];
    assign rd    = instr_r[15:11];
    assign funct = instr_r[5:0];
    assign imm   = instr_r[15:0];

    // Pipeline register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pc_r    <= RESET_PC;
            instr_r <= '0;
        end else if (fs.id_allowin_out) begin
            valid_r <= fs.if_valid_in;
            if (fs.if_valid_in) begin
                pc_r    <= fs.if_pc_in;
                instr_r <= fs.if_instr_in;
            end
        end
    end

    // Forwarding: a load in EX has no data yet, so it never forwards (the
    // stall below covers that case instead).
    assign ex_fwd_ok  = ex_valid_in && ex_wen_in && !ex_is_load_in;
    assign mem_fwd_ok = mem_valid_in && mem_wen_in;

    assign rf_raddr1 = rs;
    assign rf_raddr2 = rt;

    assign rs_val = (rs == '0)                           ? '0          :
                    (ex_fwd_ok  && ex_waddr_in  == rs)   ? ex_wdata_in :
                    (mem_fwd_ok && mem_waddr_in == rs)   ? mem_wdata_in :
                                                           rf_rdata1;
    assign rt_val = (rt == '0)                           ? '0          :
                    (ex_fwd_ok  && ex_waddr_in  == rt)   ? ex_wdata_in :
                    (mem_fwd_ok && mem_waddr_in == rt)   ? mem_wdata_in :
                                                           rf_rdata2;

    // Decode: register usage, destination, immediate, branch class/condition
    always_comb begin
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        is_br   = 1'b0;
        is_jmp  = 1'b0;
        cond    = 1'b0;
        dest    = '0;
        imm_ext = {{16{imm[15]}}, imm};
        case (op)
            OP_SPECIAL: begin
                uses_rt = 1'b1;
                case (funct)
                    6'h00, 6'h02, 6'h03: begin uses_rs = 1'b0; dest = rd; end
                    6'h08:               is_jmp = 1'b1;
                    6'h09:               begin is_jmp = 1'b1; dest = rd; end
                    default:             dest = rd;
                endcase
            end
            OP_REGIMM: begin
                case (rt)
                    5'h00: begin is_br = 1'b1; cond = rs_val[31]; end
                    5'h01: begin is_br = 1'b1; cond = !rs_val[31]; end
                    5'h10: begin is_br = 1'b1; cond = rs_val[31];  dest = 5'd31; end
                    5'h11: begin is_br = 1'b1; cond = !rs_val[31]; dest = 5'd31; end
                    default: ;
                endcase
            end
            OP_J:    begin uses_rs = 1'b0; is_jmp = 1'b1; end
            OP_JAL:  begin uses_rs = 1'b0; is_jmp = 1'b1; dest = 5'd31; end
            OP_BEQ:  begin uses_rt = 1'b1; is_br = 1'b1; cond = (rs_val == rt_val); end
            OP_BNE:  begin uses_rt = 1'b1; is_br = 1'b1; cond = (rs_val != rt_val); end
            OP_BLEZ: begin is_br = 1'b1; cond = rs_val[31] || (rs_val == '0); end
            OP_BGTZ: begin is_br = 1'b1; cond = !rs_val[31] && (rs_val != '0); end
            6'h08, 6'h09, 6'h0A, 6'h0B: dest = rt;
            6'h0C, 6'h0D, 6'h0E: begin dest = rt; imm_ext = {16'h0000, imm}; end
            OP_LUI:  begin uses_rs = 1'b0; dest = rt; imm_ext = {imm, 16'h0000}; end
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: dest = rt;
            6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: uses_rt = 1'b1;
            default: ;
        endcase
    end

    // Load-use hazard against the instruction currently in EX
    assign stall = valid_r && ex_valid_in && ex_is_load_in && (ex_waddr_in != '0) &&
                   ((uses_rs && rs == ex_waddr_in) || (uses_rt && rt == ex_waddr_in));
    assign ready = !stall;

    assign pc_plus4  = pc_r + 32'd4;
    assign br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    assign j_target  = {pc_plus4[31:28], instr_r[25:0], 2'b00};
    // Register jumps (JR/JALR) are the only jumps under the SPECIAL opcode
    assign target    = is_br ? br_target : ((op == OP_SPECIAL) ? rs_val : j_target);

    assign fs.id_allowin_out   = !valid_r || (ready && ex_allowin_in);
    assign fs.id_brcal_res_out = valid_r && ready && (is_jmp || (is_br && cond));
    assign fs.id_bjpc_res_out  = (valid_r && (is_br || is_jmp)) ? target : '0;

    assign id_valid_out   = valid_r && ready;
    assign id_pc_out      = pc_r;
    assign id_instr_out   = instr_r;
    assign id_rs_val_out  = rs_val;
    assign id_rt_val_out  = rt_val;
    assign id_imm_ext_out = imm_ext;
    assign id_dest_out    = dest;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline, directly downstream of the fetch stage.
- Latches PC and instruction from fetch through a valid/allowin handshake.
- Reads the register file, selects operands through EX/MEM forwarding, and detects load-use hazards.
- Resolves branches and jumps in-stage; returns taken/target to fetch, so the delay-slot instruction is the one already being fetched.

Parameters:
- RESET_PC, 32'hBFC0_0000: reset value of the id_pc_out register.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- if_valid_in, in, 1: fetch holds a valid instruction.
- if_pc_in, in, 32: PC of the fetched instruction.
- if_instr_in, in, 32: fetched instruction word.
- id_allowin_out, out, 1: decode can accept from fetch this cycle.
- id_brcal_res_out, out, 1: branch/jump in decode is taken.
- id_bjpc_res_out, out, 32: branch/jump target.
- rf_raddr1, out, 5: register-file read address for rs.
- rf_raddr2, out, 5: register-file read address for rt.
- rf_rdata1, in, 32: register-file read data for rs (combinational read).
- rf_rdata2, in, 32: register-file read data for rt (combinational read).
- ex_valid_in, in, 1: EX stage valid.
- ex_wen_in, in, 1: EX instruction writes a register.
- ex_is_load_in, in, 1: EX instruction is a load.
- ex_waddr_in, in, 5: EX destination register.
- ex_wdata_in, in, 32: EX result.
- mem_valid_in, in, 1: MEM stage valid.
- mem_wen_in, in, 1: MEM instruction writes a register.
- mem_waddr_in, in, 5: MEM destination register.
- mem_wdata_in, in, 32: MEM result.
- ex_allowin_in, in, 1: EX can accept from decode.
- id_valid_out, out, 1: decode presents a valid instruction to EX.
- id_pc_out, out, 32: PC of the instruction in decode.
- id_instr_out, out, 32: instruction word in decode.
- id_rs_val_out, out, 32: forwarded rs operand.
- id_rt_val_out, out, 32: forwarded rt operand.
- id_imm_ext_out, out, 32: extended immediate.
- id_dest_out, out, 5: destination register number (0 when the instruction writes none).

Behaviour:
- Pipeline register (pc_r, instr_r, valid_r):
  - Reset: valid_r=0, pc_r=RESET_PC, instr_r=0.
  - When id_allowin_out: valid_r<=if_valid_in; if if_valid_in, also load pc_r and instr_r.
  - Otherwise hold.
- Handshake:
  - ready = !stall.
  - id_allowin_out = !valid_r || (ready && ex_allowin_in).
  - id_valid_out = valid_r && ready.
  - One instruction per cycle when unstalled.
- Decoded subset: R-type ALU/shift, JR, JALR, J, JAL, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, BLTZAL, BGEZAL, I-type ALU, LUI, loads, stores. Unknown opcodes decode as non-branch with id_dest_out=0.
- Register usage:
  - uses_rs: all instructions except J, JAL, LUI, SLL, SRL, SRA.
  - uses_rt: R-type, BEQ, BNE, stores.
- Forwarding, per operand:
  - Address 0 yields 0.
  - Otherwise priority: EX match (ex_valid_in && ex_wen_in && !ex_is_load_in && ex_waddr_in==addr), then MEM match (mem_valid_in && mem_wen_in && mem_waddr_in==addr), then register file.
- Load-use stall: stall = valid_r && ex_valid_in && ex_is_load_in && ex_waddr_in!=0 && ((uses_rs && rs==ex_waddr_in) || (uses_rt && rt==ex_waddr_in)).
- Branch resolution uses forwarded operands:
  - Compares: signed compare against 0 for BLEZ/BGTZ/BLTZ/BGEZ(AL); equality for BEQ/BNE.
  - Targets: branch = pc_r+4+(sext(imm16)<<2), 32-bit wrap; J/JAL = {(pc_r+4)[31:28], instr_r[25:0], 2'b00}; JR/JALR = rs value.
  - id_brcal_res_out = valid_r && ready && taken; J/JAL/JR/JALR are always taken.
  - id_bjpc_res_out is the target whenever a branch or jump is in decode, else 0.
  - While stalled, id_brcal_res_out=0 and id_allowin_out=0, so fetch holds and re-presents the delay slot.
- id_dest_out:
  - rd for R-type writers and JALR.
  - 31 for JAL, BLTZAL, BGEZAL (link writes even when not taken).
  - rt for I-type ALU, LUI, loads.
  - 0 otherwise.
- id_imm_ext_out: zero-extended for ANDI/ORI/XORI; {imm,16'b0} for LUI; sign-extended otherwise.
- Reset mid-operation: valid_r clears on the same edge; all outputs derived from valid_r deassert the following cycle.

Test Plan:
- Reset, then if_valid_in=1, pc=BFC00000, ADDIU $1,$0,5, ex_allowin=1 → next cycle id_valid_out=1, id_dest_out=1, id_imm_ext_out=5, id_allowin_out=1.
- BEQ $2,$3,+4 with rf_rdata1=rf_rdata2=7, pc=BFC00010 → id_brcal_res_out=1, id_bjpc_res_out=BFC00024; change rdata2=8 → brcal=0.
- EX is LW $4 (ex_is_load=1), decode holds ADDU $5,$4,$0 → id_allowin_out=0, id_valid_out=0, brcal=0; drop ex_is_load next cycle with MEM forwarding $4=0x55 → id_rs_val_out=0x55, valid resumes.
- EX writes $6=0xA, MEM writes $6=0xB, decode uses $6 → id_rs_val_out=0xA; EX/MEM target $0 with 0xFF, decode reads $0 → value 0.
- JAL 0x0100000 at pc=8FFFFFFC → target 90400000, dest 31; JR $31 with rf=80001234 → target 80001234, brcal=1.
- ex_allowin_in=0 with valid instr → id_allowin_out=0, instruction held 3 cycles unchanged; rst_n low mid-hold → id_valid_out=0 next cycle.
